// File: rtl/tls_pkg.sv
// Shared definitions for the traffic-light timer block.
// Contents:
//   tls_state_e    - timer FSM state encoding (short / long / done interval)
//   *_DEF          - default parameter constants used by tls_timer and tls_debounce
package tls_pkg;

  typedef enum logic [1:0] {
    StShort = 2'b00,
    StLong  = 2'b01,
    StDone  = 2'b10
  } tls_state_e;

  localparam int unsigned CLK_DIV_DEF    = 1000;
  localparam int unsigned TS_TICKS_DEF   = 5;
  localparam int unsigned TL_TICKS_DEF   = 25;
  localparam int unsigned DEB_CYCLES_DEF = 16;

endpackage

// File: rtl/tls_debounce.sv
// Car-sensor conditioning: 2-flop synchroniser followed by a debouncer.
// The debounced output follows the synchronised input only after it has
// disagreed with the output for DEB_CYCLES consecutive clock edges.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   car_raw - asynchronous car sensor input
//   c       - synchronised, debounced car-present flag
module tls_debounce
  import tls_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic car_raw,
  output logic c
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] DebMax = CntW'(DEB_CYCLES - 1);

  if (DEB_CYCLES == 0) begin : g_param_err
    $error("tls_debounce: DEB_CYCLES must be non-zero");
  end

  logic            meta_q;
  logic            sync_q;
  logic            c_q;
  logic            c_d;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      c_q     <= 1'b0;
      count_q <= '0;
    end else begin
      meta_q  <= car_raw;
      sync_q  <= meta_q;
      c_q     <= c_d;
      count_q <= count_d;
    end
  end

  // The count holds the number of edges already seen with sync != c; the edge
  // that would make it DEB_CYCLES commits the new value instead.
  always_comb begin
    c_d     = c_q;
    count_d = count_q;
    if (sync_q == c_q) begin
      count_d = '0;
    end else if (count_q == DebMax) begin
      c_d     = sync_q;
      count_d = '0;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  assign c = c_q;

endmodule

// File: rtl/tls_timer.sv
// Traffic-light interval timer with car-sensor conditioning.
// A prescaler divides clk into ticks; an elapsed-tick counter drives a
// three-state FSM (short, long, done). A start request restarts timing.
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset
//   st      - start-timer request, sampled synchronously
//   car_raw - asynchronous car sensor
//   ts      - short interval elapsed (high in long and done)
//   tl      - long interval elapsed (high in done)
//   c       - synchronised, debounced car-present flag
module tls_timer
  import tls_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned TS_TICKS   = TS_TICKS_DEF,
  parameter int unsigned TL_TICKS   = TL_TICKS_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic st,
  input  logic car_raw,
  output logic ts,
  output logic tl,
  output logic c
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(TL_TICKS + 1);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CntTs  = CntW'(TS_TICKS);
  localparam logic [CntW-1:0] CntTl  = CntW'(TL_TICKS);

  if (TS_TICKS >= TL_TICKS || TS_TICKS == 0 || CLK_DIV == 0) begin : g_param_err
    $error("tls_timer: need 0 < TS_TICKS < TL_TICKS and CLK_DIV > 0");
  end

  tls_state_e      state_q;
  tls_state_e      state_d;
  logic [DivW-1:0] div_q;
  logic [DivW-1:0] div_d;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic [CntW-1:0] cnt_inc;
  logic            tick;

  // Reset leaves the timer exactly as a start request would, so timing after
  // release matches timing after st.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StShort;
      div_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    cnt_inc = cnt_q + 1'b1;
    if (st) begin
      // Restart wins over any coincident tick.
      state_d = StShort;
      div_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StShort, StLong: begin
          tick = (div_q == DivMax);
          if (tick) begin
            div_d = '0;
            cnt_d = cnt_inc;
            if (state_q == StShort && cnt_inc == CntTs) begin
              state_d = StLong;
            end
            if (state_q == StLong && cnt_inc == CntTl) begin
              state_d = StDone;
            end
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        StDone: begin
          // Prescaler and counter frozen until the next start.
        end
        default: begin
          state_d = StShort;
          div_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; st has no combinational path here.
  assign ts = (state_q == StLong) || (state_q == StDone);
  assign tl = (state_q == StDone);

  tls_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .car_raw(car_raw),
    .c      (c)
  );

endmodule

// File: tb/tb_tls_timer.sv
// Self-checking bench for tls_timer. The reference model tracks elapsed clock
// edges since the last start (or reset) and a sliding window of synchronised
// car samples; outputs are compared on every falling edge.
module tb_tls_timer;

  localparam int unsigned CLK_DIV    = 4;
  localparam int unsigned TS_TICKS   = 2;
  localparam int unsigned TL_TICKS   = 5;
  localparam int unsigned DEB_CYCLES = 3;
  localparam int unsigned TS_EDGES   = TS_TICKS * CLK_DIV;
  localparam int unsigned TL_EDGES   = TL_TICKS * CLK_DIV;

  logic clk;
  logic rst;
  logic st;
  logic car_raw;
  logic ts;
  logic tl;
  logic c;

  int checks;
  int errors;

  // Reference model state.
  int unsigned elapsed;
  logic        meta_m;
  logic        c_m;
  logic        win [DEB_CYCLES];

  tls_timer #(
    .CLK_DIV   (CLK_DIV),
    .TS_TICKS  (TS_TICKS),
    .TL_TICKS  (TL_TICKS),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .car_raw(car_raw),
    .ts     (ts),
    .tl     (tl),
    .c      (c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, actual, expected);
    end
  endtask

  task automatic model_reset();
    elapsed = 0;
    meta_m  = 1'b0;
    c_m     = 1'b0;
    for (int i = 0; i < int'(DEB_CYCLES); i++) win[i] = 1'b0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic st_v, input logic car_v);
    logic all_diff;
    if (st_v) elapsed = 0;
    else if (elapsed < TL_EDGES) elapsed++;
    // c flips once the last DEB_CYCLES synchronised samples all disagree with it.
    all_diff = 1'b1;
    for (int i = 0; i < int'(DEB_CYCLES); i++) if (win[i] == c_m) all_diff = 1'b0;
    if (all_diff) c_m = ~c_m;
    for (int i = 0; i < int'(DEB_CYCLES) - 1; i++) win[i] = win[i+1];
    win[DEB_CYCLES-1] = meta_m;
    meta_m = car_v;
  endtask

  task automatic compare();
    chk("ts", ts, (elapsed >= TS_EDGES));
    chk("tl", tl, (elapsed >= TL_EDGES));
    chk("c", c, c_m);
  endtask

  // Apply inputs after a falling edge, clock once, check at the next falling edge.
  task automatic step(input logic st_v, input logic car_v);
    st      = st_v;
    car_raw = car_v;
    @(posedge clk);
    model_edge(st_v, car_v);
    @(negedge clk);
    compare();
  endtask

  // Asynchronous reset pulse between rising edges.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1 model_reset();
    chk("rst_ts", ts, 1'b0);
    chk("rst_tl", tl, 1'b0);
    chk("rst_c", c, 1'b0);
    #1 rst = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    st      = 1'b0;
    car_raw = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ts", ts, 1'b0);
    chk("reset_tl", tl, 1'b0);
    chk("reset_c", c, 1'b0);
    rst = 1'b0;

    // Release with st low, car held high from before edge 1.
    for (int e = 1; e <= 24; e++) begin
      step(1'b0, 1'b1);
      if (e == 4)  chk("c_pre_deb", c, 1'b0);
      if (e == 5)  chk("c_deb_rise", c, 1'b1);
      if (e == 7)  chk("ts_edge7", ts, 1'b0);
      if (e == 8)  chk("ts_edge8", ts, 1'b1);
      if (e == 19) chk("tl_edge19", tl, 1'b0);
      if (e == 20) chk("tl_edge20", tl, 1'b1);
    end
    // Car falls; c follows five edges later while ts/tl stay high.
    for (int f = 1; f <= 6; f++) begin
      step(1'b0, 1'b0);
      if (f == 4) chk("c_hold", c, 1'b1);
      if (f == 5) chk("c_deb_fall", c, 1'b0);
      if (f == 6) chk("tl_stays", tl, 1'b1);
    end
    // Two-cycle glitch must not reach c.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int g = 1; g <= 8; g++) begin
      step(1'b0, 1'b0);
      if (g == 8) chk("glitch_c", c, 1'b0);
    end

    // Single-cycle st while in LONG.
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    chk("in_long_ts", ts, 1'b1);
    chk("in_long_tl", tl, 1'b0);
    step(1'b1, 1'b0);
    chk("st_clears_ts", ts, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      if (e == 7) chk("restart_ts7", ts, 1'b0);
      if (e == 8) chk("restart_ts8", ts, 1'b1);
    end

    // st on a tick edge (12 edges after the last start) must not count the tick.
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      if (e == 4) chk("tick_ovr_ts4", ts, 1'b0);
      if (e == 7) chk("tick_ovr_ts7", ts, 1'b0);
      if (e == 8) chk("tick_ovr_ts8", ts, 1'b1);
    end

    // Reset while in DONE with c high.
    repeat (20) step(1'b0, 1'b1);
    chk("done_tl", tl, 1'b1);
    chk("done_c", c, 1'b1);
    pulse_reset();
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b1);
      if (e == 7) chk("post_rst_ts7", ts, 1'b0);
      if (e == 8) chk("post_rst_ts8", ts, 1'b1);
    end

    // st held high for 30 cycles.
    for (int e = 1; e <= 30; e++) begin
      step(1'b1, 1'b0);
      chk("st_held_ts", ts, 1'b0);
      chk("st_held_tl", tl, 1'b0);
    end
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 1'b0);
      if (e == 7) chk("held_rel_ts7", ts, 1'b0);
      if (e == 8) chk("held_rel_ts8", ts, 1'b1);
    end

    // Randomised traffic: sparse starts, bursty car sensor, rare resets.
    begin
      logic car_v;
      car_v = 1'b0;
      for (int n = 0; n < 3000; n++) begin
        if ($urandom_range(5, 0) == 0) car_v = ~car_v;
        if ($urandom_range(599, 0) == 0) pulse_reset();
        step(($urandom_range(39, 0) == 0), car_v);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
